stimulus_arbiter: RTL

//   Latches external stimulus requests and issues at most one grant per model

---
 rtl/stimulus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stimulus_arbiter.sv
// stimulus_arbiter: latches rising edges on the stimulus inputs and hands out
// at most one one-hot grant per model tick, round-robin. A per-channel
// habituation counter blocks the same stimulus for COOLDOWN ticks after it
// has been granted; edges dropped because of it raise a one-cycle 'ignored'.
module stimulus_arbiter #(
  parameter int N_REQ    = 7,
  parameter int COOLDOWN = 4,
  parameter int CW       = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   tick,
  input  logic                                   enable,
  input  logic                                   flush,
  input  logic [N_REQ-1:0]                       req,
  output logic [N_REQ-1:0]                       pending,
  output logic [N_REQ-1:0]                       grant,
  output logic                                   grant_vld,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                                   ignored
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   req_q;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic               ignored_q, ignored_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cool_q [N_REQ];
  logic [CW-1:0]      cool_d [N_REQ];

  logic [N_REQ-1:0]   rise;
  logic [N_REQ-1:0]   cool_nz;
  logic [N_REQ-1:0]   win_vec;
  logic               arb_go;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand_idx;
  int unsigned        cand;

  // Edge detect and cooldown-active flags per channel.
  always_comb begin
    rise = req & ~req_q;
    for (int i = 0; i < N_REQ; i++) begin
      cool_nz[i] = (cool_q[i] != '0);
    end
  end

  // Round-robin search: first pending channel at or after ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IW'(cand);
      if (!win_found && pending_q[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Flush beats a same-cycle grant, so it vetoes arbitration outright.
  assign arb_go  = tick & enable & win_found & ~flush;
  assign win_vec = arb_go ? (N_REQ'(1) << win_idx) : '0;

  // Next-state: FSM, grant registers, pending latch, pointer and cooldowns.
  always_comb begin
    state_d    = arb_go ? GRANT : IDLE;
    grant_d    = win_vec;
    grant_id_d = arb_go ? win_idx : grant_id_q;
    ptr_d      = ptr_q;
    if (arb_go) begin
      ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);
    end

    // A rise during flush is discarded silently; otherwise an edge hitting a
    // cooling channel or the channel being granted right now is dropped.
    ignored_d = ~flush & (|(rise & (cool_nz | win_vec)));
    if (flush) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~win_vec) | (rise & ~cool_nz & ~win_vec);
    end

    // The freshly loaded counter is not decremented on its own grant tick.
    for (int i = 0; i < N_REQ; i++) begin
      cool_d[i] = cool_q[i];
      if (win_vec[i]) begin
        cool_d[i] = CW'(COOLDOWN);
      end else if (tick && cool_nz[i]) begin
        cool_d[i] = cool_q[i] - CW'(1);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      pending_q  <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      ignored_q  <= 1'b0;
      ptr_q      <= '0;
      // NOTE: the cooldown array is a handful of flops, not a RAM, and must
      // start cleared, so it is reset element by element.
      for (int i = 0; i < N_REQ; i++) cool_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ignored_q  <= ignored_d;
      ptr_q      <= ptr_d;
      for (int i = 0; i < N_REQ; i++) cool_q[i] <= cool_d[i];
    end
  end

  assign pending   = pending_q;
  assign grant     = grant_q;
  assign grant_vld = (state_q == GRANT);
  assign grant_id  = grant_id_q;
  assign ignored   = ignored_q;

endmodule
